// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind a valid/ready request channel with a fixed response latency.
// Handles byte-lane stores, sign/zero-extended loads and flags misaligned, illegal or out-of-range accesses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers at a rising edge where req_valid and req_ready are both high;
    // req_ready is high only in IDLE with reset released, and rsp_valid pulses for exactly one cycle.

    localparam int         AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    localparam bit         DIRECT = (LATENCY == 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_commit;
    logic        w_sel_live;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [2:0]  w_funct3;
    logic        w_legal_f3;
    logic        w_misal;
    logic        w_in_range;
    logic        w_err;
    logic [AW-1:0] w_idx;
    logic [31:0] w_word;
    logic [31:0] w_lane;
    logic [31:0] w_ext;
    logic [31:0] w_load_data;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic        w_mem_we;

    assign req_ready = reset && (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_commit  = reset && ((DIRECT && w_accept) || ((r_state == S_WAIT) && (r_cnt <= 4'd1)));

    // With a one-cycle latency the commit edge is the accept edge, so decode the live request fields.
    assign w_sel_live = (r_state == S_IDLE);
    assign w_we       = w_sel_live ? req_we     : r_we;
    assign w_addr     = w_sel_live ? req_addr   : r_addr;
    assign w_wdata    = w_sel_live ? req_wdata  : r_wdata;
    assign w_funct3   = w_sel_live ? req_funct3 : r_funct3;

    always_comb begin
        w_legal_f3 = 1'b0;
        if (w_we) begin
            w_legal_f3 = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010);
        end else begin
            w_legal_f3 = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010) ||
                         (w_funct3 == 3'b100) || (w_funct3 == 3'b101);
        end
    end

    assign w_misal    = ((w_funct3[1:0] == 2'b01) && w_addr[0]) ||
                        ((w_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
    assign w_in_range = (w_addr[31:2] < 30'(DEPTH_WORDS));
    assign w_err      = !w_legal_f3 || w_misal || !w_in_range;
    assign w_idx      = w_addr[AW+1:2];

    assign w_word = r_mem[w_idx];
    assign w_lane = w_word >> {w_addr[1:0], 3'b000};

    always_comb begin
        w_ext = 32'd0;
        case (w_funct3)
            3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_ext = w_lane;
            3'b100:  w_ext = {24'd0, w_lane[7:0]};
            3'b101:  w_ext = {16'd0, w_lane[15:0]};
            default: w_ext = 32'd0;
        endcase
    end

    assign w_load_data = (w_we || w_err) ? 32'd0 : w_ext;

    always_comb begin
        w_be = 4'b0000;
        case (w_funct3[1:0])
            2'b00:   w_be = 4'b0001 << w_addr[1:0];
            2'b01:   w_be = 4'b0011 << {w_addr[1], 1'b0};
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_wd     = w_wdata << {w_addr[1:0], 3'b000};
    assign w_mem_we = w_commit && w_we && !w_err;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we     <= req_we;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_funct3 <= req_funct3;
                        if (DIRECT) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= LAT_M1;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            // Response fields are non-zero only during the RESP cycle.
            if (w_commit) begin
                r_rsp_rdata <= w_load_data;
                r_rsp_err   <= w_err;
            end else begin
                r_rsp_rdata <= 32'd0;
                r_rsp_err   <= 1'b0;
            end
        end
    end

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance checked against a byte-array memory model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [2:0]  req_funct3 [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err [2];
    logic        busy [2];
    logic [1:0]  dbg_state [2];

    int          n_vec;
    int          n_err;
    logic [31:0] last_rdata;
    logic [7:0]  mdl [2][DEPTH*4];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .busy(busy[0]), .dbg_state(dbg_state[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .busy(busy[1]), .dbg_state(dbg_state[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as bytes, access size from funct3, alignment by modulo, extension by arithmetic.
    function automatic void model(input int sel, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] f3,
                                  output logic [31:0] rd, output logic err);
        int     size;
        longint val;
        rd  = 32'd0;
        err = 1'b0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0 || (we && f3 > 3'd2)) err = 1'b1;
        else if ((addr % size) != 0) err = 1'b1;
        if ((addr / 4) >= DEPTH) err = 1'b1;
        if (err) return;
        if (we) begin
            for (int i = 0; i < size; i++) mdl[sel][int'(addr) + i] = wdata[8*i +: 8];
        end else begin
            val = 0;
            for (int i = 0; i < size; i++) val += longint'(mdl[sel][int'(addr) + i]) << (8 * i);
            if (f3 < 3'd4 && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                val -= longint'(1) << (8 * size);
            rd = val[31:0];
        end
    endfunction

    task automatic xact(input int sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, input string tag);
        logic [31:0] er;
        logic        ee;
        int          waited;
        int          lat;
        model(sel, we, addr, wdata, f3, er, ee);
        @(negedge clk);
        req_valid[sel]  = 1'b1;
        req_we[sel]     = we;
        req_addr[sel]   = addr;
        req_wdata[sel]  = wdata;
        req_funct3[sel] = f3;
        waited = 0;
        while (req_ready[sel] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, " ready_wait"}, 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        req_valid[sel]  = 1'b0;
        req_we[sel]     = 1'($urandom);
        req_addr[sel]   = $urandom;
        req_wdata[sel]  = $urandom;
        req_funct3[sel] = 3'($urandom);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[sel] === 1'b1) break;
            chk({tag, " gap busy/ready"}, 32'({busy[sel], req_ready[sel]}), 32'd2);
        end
        chk({tag, " latency"}, 32'(lat), (sel == 1) ? 32'd1 : 32'd2);
        chk({tag, " rdata"}, rsp_rdata[sel], er);
        chk({tag, " err"}, 32'(rsp_err[sel]), 32'(ee));
        last_rdata = rsp_rdata[sel];
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prior;
        logic        perr;
        logic [31:0] a;
        int          r;
        n_vec = 0;
        n_err = 0;
        for (int s = 0; s < 2; s++) begin
            req_valid[s]  = 1'b0;
            req_we[s]     = 1'b0;
            req_addr[s]   = 32'd0;
            req_wdata[s]  = 32'd0;
            req_funct3[s] = 3'd0;
        end

        // Reset held low for three edges with a request pending.
        reset = 1'b0;
        req_valid[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst ready", 32'(req_ready[0]), 32'd0);
            chk("rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
            chk("rst rdata", rsp_rdata[0], 32'd0);
            chk("rst ready l1", 32'(req_ready[1]), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("release ready", 32'(req_ready[0]), 32'd1);
        chk("release busy", 32'(busy[0]), 32'd0);
        chk("release ready l1", 32'(req_ready[1]), 32'd1);

        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 16; w++)
                xact(s, 1'b1, 32'(4 * w), $urandom, 3'd2, "prefill");

        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, "sw 10");
        xact(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw 10");
        chk("lw 10 const", last_rdata, 32'hDEADBEEF);

        xact(0, 1'b1, 32'h13, 32'h5A5A5A80, 3'd0, "sb 13");
        xact(0, 1'b0, 32'h13, 32'h0, 3'd0, "lb 13");
        chk("lb 13 const", last_rdata, 32'hFFFFFF80);
        xact(0, 1'b0, 32'h13, 32'h0, 3'd4, "lbu 13");
        chk("lbu 13 const", last_rdata, 32'h00000080);
        xact(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw 10b");
        chk("lw 10b const", last_rdata, 32'h80ADBEEF);

        xact(0, 1'b1, 32'h12, 32'h0000F234, 3'd1, "sh 12");
        xact(0, 1'b0, 32'h12, 32'h0, 3'd5, "lhu 12");
        chk("lhu 12 const", last_rdata, 32'h0000F234);
        xact(0, 1'b0, 32'h12, 32'h0, 3'd1, "lh 12");
        chk("lh 12 const", last_rdata, 32'hFFFFF234);
        xact(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw 10c");
        chk("lw 10c const", last_rdata, 32'hF234BEEF);

        xact(0, 1'b0, 32'h11, 32'h0, 3'd1, "err lh 11");
        xact(0, 1'b1, 32'h16, 32'hCAFEBABE, 3'd2, "err sw 16");
        xact(0, 1'b0, 32'h1000, 32'h0, 3'd2, "err lw 1000");
        xact(0, 1'b0, 32'h10, 32'h0, 3'd3, "err f3 011");
        xact(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw 10d");
        chk("lw 10d const", last_rdata, 32'hF234BEEF);

        // Store dropped by a reset that lands on its commit edge.
        model(0, 1'b0, 32'h20, 32'h0, 3'd2, prior, perr);
        @(negedge clk);
        req_valid[0]  = 1'b1;
        req_we[0]     = 1'b1;
        req_addr[0]   = 32'h20;
        req_wdata[0]  = 32'h11111111;
        req_funct3[0] = 3'd2;
        chk("rstmid ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstmid rsp_valid", 32'(rsp_valid[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        xact(0, 1'b0, 32'h20, 32'h0, 3'd2, "lw 20 after rst");
        chk("lw 20 prior", last_rdata, prior);

        for (int k = 0; k < 6; k++) begin
            xact(1, 1'b1, 32'(4 * k), $urandom, 3'd2, "l1 sw");
            xact(1, 1'b0, 32'(4 * k + 1), 32'h0, 3'(k % 2 == 0 ? 0 : 4), "l1 lb");
            xact(1, 1'b0, 32'(4 * k), 32'h0, 3'd2, "l1 lw");
        end

        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) a = 32'h1000 + $urandom_range(0, 255);
            else if (r == 1) a = $urandom;
            else a = $urandom_range(0, 63);
            xact(n % 4 == 3 ? 1 : 0, 1'($urandom_range(0, 1)), a, $urandom,
                 3'($urandom_range(0, 7)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
